sub_bytes_engine: RTL and testbench

SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/sbox_lut.sv | 21 ++
 rtl/sub_bytes_engine.sv | 121 ++++++++++++
 tb/tb_sub_bytes_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants for the SubBytes engine: FIPS-197 forward/inverse
// S-box tables, block geometry and the engine's FSM state type.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int NBYTES  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    // Row-major tables: index = {row (high nibble), column (low nibble)}.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lut.sv
// Single-byte combinational substitution: forward S-box when mode=0,
// inverse S-box when mode=1.
module sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       mode,
    output logic [7:0] dout
);

    // Table lookup selected by direction.
    always_comb begin
        dout = SBOX[din];
        if (mode) begin
            dout = INV_SBOX[din];
        end else begin
            dout = SBOX[din];
        end
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / invSubBytes engine: substitutes LANES bytes of the
// latched block per clock and publishes the whole block atomically on completion.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [0:BLOCK_W-1] state,
    output logic [0:BLOCK_W-1] stateOut,
    output logic               busy,
    output logic               subBytesDone
);

    localparam int NGROUPS = NBYTES / LANES;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGROUPS - 1);
    localparam logic [CNT_W-1:0] GRP_ONE  = CNT_W'(1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("sub_bytes_engine: LANES must be one of 1, 2, 4, 8, 16");
    end

    fsm_e               fsm_q, fsm_d;
    logic [0:BLOCK_W-1] work_q, work_d;
    logic [0:BLOCK_W-1] state_out_q, state_out_d;
    logic [CNT_W-1:0]   grp_q, grp_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         lane_in  [LANES];
    logic [7:0]         lane_out [LANES];

    // Gather the bytes of the current group from the working register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[8 * (int'(grp_q) * LANES + l) +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lut u_lut (
            .din  (lane_in[l]),
            .mode (mode_q),
            .dout (lane_out[l])
        );
    end

    // Next-state logic: accept a block in IDLE, substitute one group per RUN edge.
    always_comb begin
        fsm_d       = fsm_q;
        work_d      = work_q;
        state_out_d = state_out_q;
        grp_d       = grp_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    fsm_d  = ST_RUN;
                    work_d = state;
                    mode_d = mode;
                    grp_d  = '0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[8 * (int'(grp_q) * LANES + l) +: 8] = lane_out[l];
                end
                // The final group's bytes go straight into stateOut alongside the rest.
                if (grp_q == LAST_GRP) begin
                    state_out_d = work_d;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    grp_d       = '0;
                    fsm_d       = ST_IDLE;
                end else begin
                    grp_d = grp_q + GRP_ONE;
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                grp_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Register update; reset clears everything and aborts any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            work_q      <= '0;
            state_out_q <= '0;
            grp_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            work_q      <= work_d;
            state_out_q <= state_out_d;
            grp_q       <= grp_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stateOut     = state_out_q;
    assign busy         = busy_q;
    assign subBytesDone = done_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench: three engines (LANES = 1, 4, 16) share random and directed
// stimulus; a GF(2^8)-derived reference model predicts results and timing.
module tb_sub_bytes_engine;

    localparam int NG_TAB [3] = '{16, 4, 1};

    typedef struct {
        int           inst;
        logic [0:127] exp;
        int           start;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [0:127] state_in = '0;
    logic [0:127] so_a   [3];
    logic         busy_a [3];
    logic         done_a [3];

    logic [7:0]   tb_sbox [256];
    logic [7:0]   tb_inv  [256];
    exp_t         sbq [$];
    int           free_e [3] = '{0, 0, 0};
    logic [0:127] so_exp [3] = '{'0, '0, '0};
    int           edges = 0;
    logic         rst_seen = 1'b0;
    logic         stop_req = 1'b0;
    int           drain_cnt = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LN = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
        sub_bytes_engine #(.LANES(LN)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .mode         (mode),
            .state        (state_in),
            .stateOut     (so_a[gi]),
            .busy         (busy_a[gi]),
            .subBytesDone (done_a[gi])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            tb_sbox[x] = s;
            tb_inv[s]  = 8'(x);
        end
    end

    function automatic logic [0:127] ref_sub(input logic [0:127] d, input logic m);
        logic [0:127] r;
        for (int b = 0; b < 16; b++) begin
            r[8*b +: 8] = m ? tb_inv[d[8*b +: 8]] : tb_sbox[d[8*b +: 8]];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        edges    = edges + 1;
        rst_seen = rst;
    end

    // Drive one cycle of inputs and predict acceptance for every engine.
    task automatic drive(input logic s, input logic [0:127] d, input logic m, input logic r,
                         input logic use_kat, input logic [0:127] kat);
        int e;
        exp_t it;
        @(posedge clk);
        #1;
        start = s; state_in = d; mode = m; rst = r;
        e = edges + 1;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                free_e[i] = e + 1;
            end else if (s && e >= free_e[i]) begin
                it.inst  = i;
                it.exp   = use_kat ? kat : ref_sub(d, m);
                it.start = e;
                it.due   = e + NG_TAB[i];
                sbq.push_back(it);
                free_e[i] = e + NG_TAB[i] + 1;
            end
        end
    endtask

    task automatic wait_idle();
        int mx;
        for (int c = 0; c < 40; c++) begin
            mx = 0;
            for (int i = 0; i < 3; i++) if (free_e[i] > mx) mx = free_e[i];
            if (edges + 1 < mx) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic kat_block(input logic [0:127] d, input logic m, input logic [0:127] kat);
        drive(1'b1, d, m, 1'b0, 1'b1, kat);
        drive(1'b0, ~d, ~m, 1'b0, 1'b0, '0);
        wait_idle();
    endtask

    localparam logic [0:127] VA = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] VB = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        logic [0:127] d;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        kat_block(VA, 1'b0, VB);
        kat_block(VB, 1'b1, VA);
        kat_block({16{8'h00}}, 1'b0, {16{8'h63}});
        kat_block({16{8'hff}}, 1'b0, {16{8'h16}});
        kat_block({16{8'h00}}, 1'b1, {16{8'h52}});
        kat_block({16{8'h63}}, 1'b1, {16{8'h00}});
        // Restart attempts while busy with different data.
        drive(1'b1, VA, 1'b0, 1'b0, 1'b1, VB);
        drive(1'b1, VB, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, {16{8'hff}}, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        wait_idle();
        // Start held high with alternating vectors.
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) drive(1'b1, VA, 1'b0, 1'b0, 1'b1, VB);
            else            drive(1'b1, VB, 1'b1, 1'b0, 1'b1, VA);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        wait_idle();
        // Reset in the second RUN cycle, then a normal block.
        drive(1'b1, VA, 1'b0, 1'b0, 1'b1, VB);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, VB, 1'b1, 1'b1, 1'b0, '0);
        kat_block(VA, 1'b0, VB);
        for (int c = 0; c < 400; c++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 2) == 0), d, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0), 1'b0, '0);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        stop_req = 1'b1;
    end

    // Monitor: flush on reset, pop on completion, check outputs every cycle.
    always @(negedge clk) begin
        if (rst_seen) begin
            for (int k = sbq.size() - 1; k >= 0; k--) begin
                if (sbq[k].start <= edges) sbq.delete(k);
            end
            for (int i = 0; i < 3; i++) so_exp[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            int   hit;
            logic busy_exp;
            logic done_exp;
            hit = -1; busy_exp = 1'b0; done_exp = 1'b0;
            for (int k = 0; k < sbq.size(); k++) begin
                if (sbq[k].inst == i) begin
                    if (hit < 0) hit = k;
                    if (sbq[k].start <= edges && edges < sbq[k].due) busy_exp = 1'b1;
                end
            end
            if (hit >= 0 && sbq[hit].due == edges) done_exp = 1'b1;
            n_tests = n_tests + 1;
            if (done_a[i] !== done_exp) begin
                n_fail = n_fail + 1;
                $display("FAIL done inst=%0d edge=%0d got=%b want=%b", i, edges, done_a[i], done_exp);
            end
            n_tests = n_tests + 1;
            if (busy_a[i] !== busy_exp) begin
                n_fail = n_fail + 1;
                $display("FAIL busy inst=%0d edge=%0d got=%b want=%b", i, edges, busy_a[i], busy_exp);
            end
            if (done_exp) begin
                so_exp[i] = sbq[hit].exp;
                sbq.delete(hit);
            end
            n_tests = n_tests + 1;
            if (so_a[i] !== so_exp[i]) begin
                n_fail = n_fail + 1;
                $display("FAIL stateOut inst=%0d edge=%0d got=%h want=%h", i, edges, so_a[i], so_exp[i]);
            end
        end
        if (stop_req) begin
            drain_cnt = drain_cnt + 1;
            if (sbq.size() == 0 || drain_cnt > 60) begin
                n_tests = n_tests + 1;
                if (sbq.size() != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL drain pending=%0d want=0", sbq.size());
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
